// File: rtl/leaf_stream_buffer.sv
// Per-channel elastic FIFO buffer between the leaf interface and an HLS user operator.
// First-word fall-through, per-channel flush, occupancy report and delivered-word counters.
module leaf_stream_buffer #(
    parameter int NUM_CH       = 2,
    parameter int PAYLOAD_BITS = 32,
    parameter int DEPTH_BITS   = 4,
    parameter int CNT_BITS     = 32
) (
    input  logic                                clk_user,
    input  logic                                reset,
    input  logic [NUM_CH*PAYLOAD_BITS-1:0]      in_data,
    input  logic [NUM_CH-1:0]                   in_vld,
    output logic [NUM_CH-1:0]                   in_ack,
    output logic [NUM_CH*PAYLOAD_BITS-1:0]      out_data,
    output logic [NUM_CH-1:0]                   out_vld,
    input  logic [NUM_CH-1:0]                   out_ack,
    input  logic [NUM_CH-1:0]                   flush,
    output logic [NUM_CH*(DEPTH_BITS+1)-1:0]    occupancy,
    output logic [NUM_CH*CNT_BITS-1:0]          xfer_count
);

    localparam int                  DEPTH    = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] OCC_FULL = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] OCC_ZERO = (DEPTH_BITS+1)'(0);
    localparam logic [DEPTH_BITS:0] OCC_ONE  = (DEPTH_BITS+1)'(1);
    localparam logic [DEPTH_BITS-1:0] PTR_ZERO = DEPTH_BITS'(0);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_ZERO = CNT_BITS'(0);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [PAYLOAD_BITS-1:0] r_mem [DEPTH];
        logic [DEPTH_BITS-1:0]   r_wr_ptr;
        logic [DEPTH_BITS-1:0]   r_rd_ptr;
        logic [DEPTH_BITS:0]     r_occ;
        logic [CNT_BITS-1:0]     r_xfer;
        logic                    w_full;
        logic                    w_empty;
        logic                    w_in_ack;
        logic                    w_push;
        logic                    w_pop;
        logic [DEPTH_BITS:0]     w_occ_next;

        // Handshake qualification and next occupancy; acceptance never looks at in_vld.
        always_comb begin
            w_full   = (r_occ == OCC_FULL);
            w_empty  = (r_occ == OCC_ZERO);
            w_in_ack = !w_full && !flush[gi] && !reset;
            w_push   = in_vld[gi] && w_in_ack;
            w_pop    = !w_empty && out_ack[gi];
            if (w_push && !w_pop) begin
                w_occ_next = r_occ + OCC_ONE;
            end else if (!w_push && w_pop) begin
                w_occ_next = r_occ - OCC_ONE;
            end else begin
                w_occ_next = r_occ;
            end
        end

        // Pointer, occupancy and delivered-count state; a pop during flush still counts.
        always_ff @(posedge clk_user) begin
            if (reset) begin
                r_wr_ptr <= PTR_ZERO;
                r_rd_ptr <= PTR_ZERO;
                r_occ    <= OCC_ZERO;
                r_xfer   <= CNT_ZERO;
            end else if (flush[gi]) begin
                r_wr_ptr <= PTR_ZERO;
                r_rd_ptr <= PTR_ZERO;
                r_occ    <= OCC_ZERO;
                if (w_pop) begin
                    r_xfer <= r_xfer + CNT_ONE;
                end
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                    r_xfer   <= r_xfer + CNT_ONE;
                end
                r_occ <= w_occ_next;
            end
        end

        // Payload storage; contents are deliberately left unreset.
        always_ff @(posedge clk_user) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data[gi*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end

        assign in_ack[gi]                                      = w_in_ack;
        assign out_vld[gi]                                     = !w_empty;
        assign out_data[gi*PAYLOAD_BITS +: PAYLOAD_BITS]       = r_mem[r_rd_ptr];
        assign occupancy[gi*(DEPTH_BITS+1) +: (DEPTH_BITS+1)]  = r_occ;
        assign xfer_count[gi*CNT_BITS +: CNT_BITS]             = r_xfer;
    end

endmodule

// File: tb/tb_leaf_stream_buffer.sv
// Self-checking bench for leaf_stream_buffer: vector table, directed corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_leaf_stream_buffer;

    localparam int NCH = 2;
    localparam int PB  = 32;
    localparam int DB  = 4;
    localparam int CB  = 4;
    localparam int D   = 16;

    logic                  clk_user = 1'b0;
    logic                  reset;
    logic [NCH*PB-1:0]     in_data;
    logic [NCH-1:0]        in_vld;
    logic [NCH-1:0]        in_ack;
    logic [NCH*PB-1:0]     out_data;
    logic [NCH-1:0]        out_vld;
    logic [NCH-1:0]        out_ack;
    logic [NCH-1:0]        flush;
    logic [NCH*(DB+1)-1:0] occupancy;
    logic [NCH*CB-1:0]     xfer_count;

    leaf_stream_buffer #(
        .NUM_CH(NCH), .PAYLOAD_BITS(PB), .DEPTH_BITS(DB), .CNT_BITS(CB)
    ) dut (
        .clk_user(clk_user), .reset(reset),
        .in_data(in_data), .in_vld(in_vld), .in_ack(in_ack),
        .out_data(out_data), .out_vld(out_vld), .out_ack(out_ack),
        .flush(flush), .occupancy(occupancy), .xfer_count(xfer_count)
    );

    always #5 clk_user = ~clk_user;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: one FIFO queue and one wrapping delivered count per channel.
    logic [31:0] mq [2][$];
    int          mcnt [2];

    typedef struct {
        logic [1:0]  vld;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  oack;
        logic [1:0]  fl;
        logic [4:0]  exp_occ0;
        logic [4:0]  exp_occ1;
        logic [1:0]  exp_ovld;
        logic        chk_d;
        logic [31:0] exp_d0;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] oa, input logic [1:0] fl);
        in_vld  = v;
        in_data = {d1, d0};
        out_ack = oa;
        flush   = fl;
    endtask

    function automatic logic [4:0] occ(input int c);
        return occupancy[c*5 +: 5];
    endfunction

    function automatic logic [3:0] xc(input int c);
        return xfer_count[c*4 +: 4];
    endfunction

    // One clock: check all outputs against the model, take the edge, advance the model.
    task automatic cycle();
        logic [1:0] push;
        logic [1:0] pop;
        logic       exp_ack;
        logic [31:0] junk;
        #1;
        for (int c = 0; c < 2; c++) begin
            exp_ack = !reset && !flush[c] && (mq[c].size() < D);
            chk("in_ack", 32'(in_ack[c]), 32'(exp_ack));
            chk("out_vld", 32'(out_vld[c]), 32'(mq[c].size() != 0));
            if (mq[c].size() != 0) begin
                chk("out_data", out_data[c*32 +: 32], mq[c][0]);
            end
            chk("occupancy", 32'(occ(c)), 32'(mq[c].size()));
            chk("xfer_count", 32'(xc(c)), 32'(mcnt[c]));
            push[c] = in_vld[c] && exp_ack;
            pop[c]  = out_ack[c] && (mq[c].size() != 0);
        end
        @(posedge clk_user);
        for (int c = 0; c < 2; c++) begin
            if (reset) begin
                mq[c].delete();
                mcnt[c] = 0;
            end else begin
                if (pop[c]) begin
                    junk    = mq[c].pop_front();
                    mcnt[c] = (mcnt[c] + 1) % 16;
                end
                if (flush[c]) begin
                    mq[c].delete();
                end else if (push[c]) begin
                    mq[c].push_back(in_data[c*32 +: 32]);
                end
            end
        end
        #1;
    endtask

    initial begin
        int base0;
        int x1;
        logic [4:0] o1;

        tbl[0] = '{2'b01, 32'hA000_0001, 32'h0, 2'b00, 2'b00, 5'd1, 5'd0, 2'b01, 1'b1, 32'hA000_0001};
        tbl[1] = '{2'b01, 32'hA000_0002, 32'h0, 2'b00, 2'b00, 5'd2, 5'd0, 2'b01, 1'b1, 32'hA000_0001};
        tbl[2] = '{2'b01, 32'hA000_0003, 32'h0, 2'b00, 2'b00, 5'd3, 5'd0, 2'b01, 1'b1, 32'hA000_0001};
        tbl[3] = '{2'b00, 32'h0,         32'h0, 2'b01, 2'b00, 5'd2, 5'd0, 2'b01, 1'b1, 32'hA000_0002};
        tbl[4] = '{2'b00, 32'h0,         32'h0, 2'b01, 2'b00, 5'd1, 5'd0, 2'b01, 1'b1, 32'hA000_0003};
        tbl[5] = '{2'b01, 32'hA000_0004, 32'h0, 2'b01, 2'b00, 5'd1, 5'd0, 2'b01, 1'b1, 32'hA000_0004};
        tbl[6] = '{2'b00, 32'h0,         32'h0, 2'b01, 2'b00, 5'd0, 5'd0, 2'b00, 1'b0, 32'h0};
        tbl[7] = '{2'b00, 32'h0,         32'h0, 2'b01, 2'b00, 5'd0, 5'd0, 2'b00, 1'b0, 32'h0};

        reset = 1'b1;
        drive(2'b00, 32'h0, 32'h0, 2'b00, 2'b00);
        repeat (2) @(posedge clk_user);
        #1;
        mq[0].delete(); mq[1].delete();
        mcnt[0] = 0; mcnt[1] = 0;
        chk("rst_in_ack_low", 32'(in_ack), 32'h0);
        chk("rst_out_vld", 32'(out_vld), 32'h0);
        chk("rst_occupancy", 32'(occupancy), 32'h0);
        chk("rst_xfer", 32'(xfer_count), 32'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ack", 32'(in_ack), 32'h3);

        // Vector table: basic push, FWFT head, pop, simultaneous push/pop, empty pop.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].vld, tbl[i].d0, tbl[i].d1, tbl[i].oack, tbl[i].fl);
            cycle();
            chk("tbl_occ0", 32'(occ(0)), 32'(tbl[i].exp_occ0));
            chk("tbl_occ1", 32'(occ(1)), 32'(tbl[i].exp_occ1));
            chk("tbl_out_vld", 32'(out_vld), 32'(tbl[i].exp_ovld));
            if (tbl[i].chk_d) begin
                chk("tbl_out_data0", out_data[31:0], tbl[i].exp_d0);
            end
        end

        // Fill ch1 to full, refused 17th word, pop-then-accept.
        for (int i = 0; i < 16; i++) begin
            drive(2'b10, 32'h0, 32'hB000_0000 + 32'(i), 2'b00, 2'b00);
            cycle();
        end
        chk("full_occ1", 32'(occ(1)), 32'd16);
        drive(2'b10, 32'h0, 32'hB000_0010, 2'b00, 2'b00);
        #1;
        chk("full_in_ack1", 32'(in_ack[1]), 32'h0);
        cycle();
        chk("full_hold_occ1", 32'(occ(1)), 32'd16);
        drive(2'b10, 32'h0, 32'hB000_0010, 2'b10, 2'b00);
        cycle();
        chk("full_pop_occ1", 32'(occ(1)), 32'd15);
        drive(2'b10, 32'h0, 32'hB000_0010, 2'b00, 2'b00);
        cycle();
        chk("refill_occ1", 32'(occ(1)), 32'd16);
        for (int i = 0; i < 16; i++) begin
            drive(2'b00, 32'h0, 32'h0, 2'b10, 2'b00);
            cycle();
        end
        chk("drain_occ1", 32'(occ(1)), 32'd0);

        // Steady streaming at occupancy 5 across pointer wrap.
        for (int i = 0; i < 5; i++) begin
            drive(2'b01, 32'hC000_0000 + 32'(i), 32'h0, 2'b00, 2'b00);
            cycle();
        end
        base0 = mcnt[0];
        for (int i = 0; i < 20; i++) begin
            drive(2'b01, 32'hC000_0005 + 32'(i), 32'h0, 2'b01, 2'b00);
            cycle();
            chk("stream_occ0", 32'(occ(0)), 32'd5);
        end
        chk("stream_xfer0", 32'(xc(0)), 32'((base0 + 20) % 16));
        chk("stream_head0", out_data[31:0], 32'hC000_0014);

        // Flush ch0 at occupancy 7 while popping; ch1 untouched.
        for (int i = 0; i < 2; i++) begin
            drive(2'b11, 32'hC000_0019 + 32'(i), 32'hD000_0000 + 32'(i), 2'b00, 2'b00);
            cycle();
        end
        drive(2'b10, 32'h0, 32'hD000_0002, 2'b00, 2'b00);
        cycle();
        chk("pre_flush_occ0", 32'(occ(0)), 32'd7);
        base0 = int'(xc(0));
        x1    = int'(xc(1));
        o1    = occ(1);
        drive(2'b01, 32'hEEEE_EEEE, 32'h0, 2'b01, 2'b01);
        #1;
        chk("flush_in_ack0", 32'(in_ack[0]), 32'h0);
        chk("flush_in_ack1", 32'(in_ack[1]), 32'h1);
        cycle();
        chk("flush_occ0", 32'(occ(0)), 32'd0);
        chk("flush_vld0", 32'(out_vld[0]), 32'h0);
        chk("flush_xfer0", 32'(xc(0)), 32'((base0 + 1) % 16));
        chk("flush_occ1", 32'(occ(1)), 32'(o1));
        chk("flush_xfer1", 32'(xc(1)), 32'(x1));
        chk("flush_head1", out_data[63:32], 32'hD000_0000);

        // Counter wrap: 15 transfers reach 15, the 16th reads 0.
        reset = 1'b1;
        drive(2'b00, 32'h0, 32'h0, 2'b00, 2'b00);
        cycle();
        reset = 1'b0;
        drive(2'b10, 32'h0, 32'h5000_0000, 2'b00, 2'b00);
        cycle();
        for (int i = 0; i < 15; i++) begin
            drive(2'b10, 32'h0, 32'h5000_0001 + 32'(i), 2'b10, 2'b00);
            cycle();
        end
        chk("wrap_xfer1_15", 32'(xc(1)), 32'd15);
        drive(2'b00, 32'h0, 32'h0, 2'b10, 2'b00);
        cycle();
        chk("wrap_xfer1_0", 32'(xc(1)), 32'd0);

        // Mid-stream reset with both channels at occupancy 9 while pushing.
        for (int i = 0; i < 9; i++) begin
            drive(2'b11, 32'h6000_0000 + 32'(i), 32'h7000_0000 + 32'(i), 2'b00, 2'b00);
            cycle();
        end
        chk("pre_rst_occ0", 32'(occ(0)), 32'd9);
        chk("pre_rst_occ1", 32'(occ(1)), 32'd9);
        reset = 1'b1;
        drive(2'b11, 32'h6000_0009, 32'h7000_0009, 2'b11, 2'b00);
        cycle();
        chk("mid_rst_occ", 32'(occupancy), 32'h0);
        chk("mid_rst_vld", 32'(out_vld), 32'h0);
        chk("mid_rst_xfer", 32'(xfer_count), 32'h0);
        reset = 1'b0;
        drive(2'b11, 32'hE000_0001, 32'hF000_0001, 2'b00, 2'b00);
        cycle();
        chk("post_rst_head0", out_data[31:0], 32'hE000_0001);
        chk("post_rst_head1", out_data[63:32], 32'hF000_0001);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            drive(2'($urandom), $urandom, $urandom, 2'($urandom),
                  {($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0)});
            cycle();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/leaf_stream_buffer.md
Name: leaf_stream_buffer

Overview:
- Parametrised per-channel elastic buffer between the leaf interface and an HLS user operator, all on the user clock.
- Generalises the fixed two-in/two-out 32-bit vld/ack wiring into NUM_CH independent FIFO channels of configurable width and depth.
- Adds per-channel flush, occupancy reporting and delivered-word counters.
- Decouples operator stalls from the leaf interface's output path.

Parameters:
- NUM_CH, 2, number of independent channels.
- PAYLOAD_BITS, 32, data width per channel.
- DEPTH_BITS, 4, log2 of FIFO depth; depth D = 2^DEPTH_BITS = 16.
- CNT_BITS, 32, width of each delivered-word counter.

Ports:
- clk_user  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- in_data  in  NUM_CH*PAYLOAD_BITS  channel i at bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- in_vld  in  NUM_CH  producer word valid, per channel.
- in_ack  out  NUM_CH  buffer accepts, per channel.
- out_data  out  NUM_CH*PAYLOAD_BITS  head word per channel.
- out_vld  out  NUM_CH  head word valid.
- out_ack  in  NUM_CH  consumer accepts.
- flush  in  NUM_CH  synchronous per-channel clear.
- occupancy  out  NUM_CH*(DEPTH_BITS+1)  words stored per channel, range 0..D.
- xfer_count  out  NUM_CH*CNT_BITS  words delivered on the output side, per channel.

Behaviour:
- Channels are fully independent; every rule below applies per channel i.

Handshake:
- A transfer occurs on a clock edge where vld and ack are both 1.
- in_ack[i] = !full[i] && !flush[i]. It is combinational from registered state and flush only; it never depends on in_vld.
- out_vld[i] = (occupancy[i] != 0), from registered state.
- out_data[i] = storage[rd_ptr]. It is stable while out_vld=1 and out_ack=0.

Latency and ordering:
- A word pushed at edge N is visible on out_vld/out_data after edge N (first-word fall-through latency 1 cycle).
- Words emerge in FIFO order.

Storage:
- D x PAYLOAD_BITS per channel.
- wr_ptr and rd_ptr are DEPTH_BITS wide and wrap modulo D.
- occupancy is a separate DEPTH_BITS+1 counter.

Occupancy update each edge (no flush):
- Push only: +1.
- Pop only: -1.
- Push and pop together: unchanged; both pointers advance.
- Neither: hold.

Full and empty:
- Full (occupancy = D): in_ack=0, so no push, even if a pop occurs in the same cycle. Accepting again takes effect the cycle after the pop.
- Empty: out_vld=0, so no pop. out_ack is ignored and out_data is don't-care.

Flush[i] = 1 at edge N:
- rd_ptr, wr_ptr and occupancy go to 0 after the edge.
- in_ack[i] is 0 during that cycle, so no push.
- A pop qualified that cycle (out_vld && out_ack) counts as delivered: xfer_count increments.
- xfer_count is not cleared by flush.
- Other channels are unaffected.

xfer_count:
- Increments by 1 on each output transfer.
- Wraps from 2^CNT_BITS-1 to 0 with no saturation or flag.

Reset:
- Reset = 1 at any edge forces, for all channels: pointers=0, occupancy=0, xfer_count=0.
- Reset has priority over flush, push and pop; a mid-stream reset discards contents.
- Outputs during and after reset: in_ack=all 1 once reset deasserts (in_ack=0 while reset=1), out_vld=0, occupancy=0, xfer_count=0.
- Storage RAM contents are not reset; out_data is don't-care while out_vld=0.

Implementation constraints:
- No combinational path from in_vld to in_ack, or from out_ack to out_vld.

Test Plan:
1. Reset, then push 0xA0000001..0xA0000003 on ch0 with out_ack=0 -> occupancy0 = 1,2,3 on successive cycles. out_vld0 rises one cycle after the first push with out_data0=0xA0000001. ch1 stays out_vld=0.
2. Fill ch1 with 16 words, out_ack=0 -> in_ack1=0 at occupancy 16. A 17th word with in_vld held is not accepted. Assert out_ack one cycle with in_vld=1 -> pop only, occupancy 15; the word is accepted on the next cycle (occupancy back to 16).
3. ch0 at occupancy 5, in_vld=out_ack=1 for 20 cycles with incrementing data -> occupancy stays 5, output order strictly incrementing, pointers wrap with no loss, xfer_count0 += 20.
4. ch0 at occupancy 7 with out_ack=1 and flush0=1 for one cycle -> next cycle occupancy0=0, out_vld0=0, xfer_count0 +1, in_ack0=0 during the flush cycle. ch1 contents and counters unchanged.
5. Preload xfer_count via 2^CNT_BITS-1 transfers (bench uses CNT_BITS=4: 15 transfers), then one more -> xfer_count reads 0.
6. Reset asserted mid-stream with both channels at occupancy 9 while pushing -> after the edge: occupancy=0, out_vld=0, xfer_count=0. The first push after reset emerges as the first output.
